// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet constants and MAC transmit state encoding
package eth_pkg;

  localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  ETH_SFD_NIB      = 4'hD;
  localparam logic [31:0] ETH_CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT     = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_WAIT_LAST
  } tx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// rtl/eth_crc32_byte.sv - one-byte step of the reflected Ethernet CRC-32
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_mac_mii_tx.sv
// rtl/eth_mac_mii_tx.sv - MII transmit stage: preamble, padding, FCS, IFG, nibble serialiser
module eth_mac_mii_tx
  import eth_pkg::*;
#(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int IFG_BYTES        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] mii_txd,
  output logic       mii_tx_en,
  output logic       mii_tx_er,
  output logic       start_packet,
  output logic       error_underflow
);

  localparam logic [15:0] MIN_DATA = 16'(MIN_FRAME_LENGTH - 4);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 2 - 1);

  tx_state_t   state, state_n;
  logic [3:0]  nib_cnt, nib_cnt_n;
  logic        phase, phase_n;
  logic [15:0] byte_cnt, byte_cnt_n;
  logic [15:0] ifg_cnt, ifg_cnt_n;
  logic [31:0] crc, crc_n, crc_next, fcs;
  logic [3:0]  hi_nib, hi_n;
  logic        last_q, last_n, user_q, user_n;
  logic [3:0]  txd_n;
  logic        tx_en_n, tx_er_n, start_n, uf_n;
  logic        start_frame, take_byte, take_pad, underflow, end_data;
  logic [7:0]  crc_byte;
  logic [2:0]  fcs_sel;

  // The state register always describes the nibble currently on the wire;
  // the byte fed to the CRC is live input data only while fetching payload.
  assign crc_byte = ((state == ST_PREAMBLE) || (state == ST_PAYLOAD && !last_q))
                    ? s_axis_tdata : 8'h00;
  assign fcs      = ~crc;
  assign fcs_sel  = nib_cnt[2:0] + 3'd1;

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    state_n       = state;
    nib_cnt_n     = nib_cnt;
    phase_n       = phase;
    byte_cnt_n    = byte_cnt;
    ifg_cnt_n     = ifg_cnt;
    crc_n         = crc;
    hi_n          = hi_nib;
    last_n        = last_q;
    user_n        = user_q;
    txd_n         = 4'h0;
    tx_en_n       = 1'b0;
    tx_er_n       = 1'b0;
    start_n       = 1'b0;
    uf_n          = 1'b0;
    s_axis_tready = 1'b0;
    start_frame   = 1'b0;
    take_byte     = 1'b0;
    take_pad      = 1'b0;
    underflow     = 1'b0;
    end_data      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s_axis_tvalid) start_frame = 1'b1;
      end
      ST_PREAMBLE: begin
        tx_en_n = 1'b1;
        if (nib_cnt != 4'd15) begin
          nib_cnt_n = nib_cnt + 4'd1;
          txd_n     = (nib_cnt == 4'd14) ? ETH_SFD_NIB : ETH_PREAMBLE_NIB;
        end else begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) take_byte = 1'b1;
          else               underflow = 1'b1;
        end
      end
      ST_PAYLOAD, ST_PAD: begin
        tx_en_n = 1'b1;
        if (!phase) begin
          phase_n = 1'b1;
          txd_n   = hi_nib;
        end else if (state == ST_PAYLOAD && !last_q) begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) take_byte = 1'b1;
          else               underflow = 1'b1;
        end else if (ENABLE_PADDING != 0 && byte_cnt < MIN_DATA) begin
          take_pad = 1'b1;
        end else begin
          end_data = 1'b1;
        end
      end
      ST_FCS: begin
        if (nib_cnt != 4'd7) begin
          nib_cnt_n = nib_cnt + 4'd1;
          tx_en_n   = 1'b1;
          tx_er_n   = user_q;
          txd_n     = fcs[{fcs_sel, 2'b00} +: 4];
        end else begin
          state_n   = ST_IFG;
          ifg_cnt_n = 16'd0;
        end
      end
      ST_WAIT_LAST: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_n   = ST_IFG;
          ifg_cnt_n = 16'd0;
        end
      end
      ST_IFG: begin
        if (ifg_cnt != IFG_LAST) ifg_cnt_n = ifg_cnt + 16'd1;
        else if (s_axis_tvalid)  start_frame = 1'b1;
        else                     state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    if (start_frame) begin
      state_n    = ST_PREAMBLE;
      nib_cnt_n  = 4'd0;
      byte_cnt_n = 16'd0;
      crc_n      = ETH_CRC_INIT;
      last_n     = 1'b0;
      user_n     = 1'b0;
      txd_n      = ETH_PREAMBLE_NIB;
      tx_en_n    = 1'b1;
      start_n    = 1'b1;
    end
    if (take_byte || take_pad) begin
      state_n    = take_pad ? ST_PAD : ST_PAYLOAD;
      phase_n    = 1'b0;
      txd_n      = crc_byte[3:0];
      hi_n       = crc_byte[7:4];
      crc_n      = crc_next;
      byte_cnt_n = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
      tx_en_n    = 1'b1;
    end
    if (take_byte) begin
      last_n = s_axis_tlast;
      if (s_axis_tlast) user_n = s_axis_tuser;
    end
    // Starvation: one errored nibble marks the truncated frame, then silence.
    if (underflow) begin
      state_n = ST_WAIT_LAST;
      tx_en_n = 1'b1;
      tx_er_n = 1'b1;
      uf_n    = 1'b1;
    end
    if (end_data) begin
      state_n   = ST_FCS;
      nib_cnt_n = 4'd0;
      txd_n     = fcs[3:0];
      tx_en_n   = 1'b1;
      tx_er_n   = user_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      nib_cnt         <= 4'd0;
      phase           <= 1'b0;
      byte_cnt        <= 16'd0;
      ifg_cnt         <= 16'd0;
      crc             <= ETH_CRC_INIT;
      hi_nib          <= 4'd0;
      last_q          <= 1'b0;
      user_q          <= 1'b0;
      mii_txd         <= 4'd0;
      mii_tx_en       <= 1'b0;
      mii_tx_er       <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      state           <= state_n;
      nib_cnt         <= nib_cnt_n;
      phase           <= phase_n;
      byte_cnt        <= byte_cnt_n;
      ifg_cnt         <= ifg_cnt_n;
      crc             <= crc_n;
      hi_nib          <= hi_n;
      last_q          <= last_n;
      user_q          <= user_n;
      mii_txd         <= txd_n;
      mii_tx_en       <= tx_en_n;
      mii_tx_er       <= tx_er_n;
      start_packet    <= start_n;
      error_underflow <= uf_n;
    end
  end

endmodule

// File: tb/tb_eth_mac_mii_tx.sv
// tb/tb_eth_mac_mii_tx.sv - self-checking bench for eth_mac_mii_tx (unpadded and padded instances)
module tb_eth_mac_mii_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tdata [2];
  logic       tvalid [2];
  logic       tlast [2];
  logic       tuser [2];
  logic       tready [2];
  logic [3:0] txd [2];
  logic       tx_en [2];
  logic       tx_er [2];
  logic       sp [2];
  logic       uf [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame_q [$];
  logic [3:0]  exp_nib [$];
  logic [3:0]  cap_nib [$];
  logic        cap_er [$];
  int          cap_sp, cap_uf;
  bit          cap_ok, drv_ok;
  logic [31:0] crc_tab [256];
  int          tr_viol = 0;
  logic        tr_prev = 1'b0;

  always #5 clk = ~clk;

  eth_mac_mii_tx #(.ENABLE_PADDING(0)) dut_nopad (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .s_axis_tlast(tlast[0]), .s_axis_tuser(tuser[0]),
    .mii_txd(txd[0]), .mii_tx_en(tx_en[0]), .mii_tx_er(tx_er[0]),
    .start_packet(sp[0]), .error_underflow(uf[0])
  );

  eth_mac_mii_tx #(.ENABLE_PADDING(1)) dut_pad (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .s_axis_tlast(tlast[1]), .s_axis_tuser(tuser[1]),
    .mii_txd(txd[1]), .mii_tx_en(tx_en[1]), .mii_tx_er(tx_er[1]),
    .start_packet(sp[1]), .error_underflow(uf[1])
  );

  // The unpadded instance never underflows, so its tready must never be high twice in a row.
  always @(negedge clk) begin
    if (tready[0] && tr_prev) tr_viol++;
    tr_prev = tready[0];
  end

  task automatic build_table();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
  endtask

  function automatic logic [31:0] model_fcs(input int total);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < total; i++) begin
      b = (i < frame_q.size()) ? frame_q[i] : 8'h00;
      c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
    end
    return ~c;
  endfunction

  task automatic build_expected(input bit pad);
    int          total;
    logic [7:0]  b;
    logic [31:0] f;
    total = frame_q.size();
    if (pad && total < 60) total = 60;
    exp_nib = {};
    repeat (15) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    for (int i = 0; i < total; i++) begin
      b = (i < frame_q.size()) ? frame_q[i] : 8'h00;
      exp_nib.push_back(b[3:0]);
      exp_nib.push_back(b[7:4]);
    end
    f = model_fcs(total);
    for (int i = 0; i < 8; i++) exp_nib.push_back(f[4*i +: 4]);
  endtask

  function automatic int first_diff(input int upto);
    for (int i = 0; i < upto; i++)
      if (i >= cap_nib.size() || i >= exp_nib.size() || cap_nib[i] !== exp_nib[i]) return i;
    return -1;
  endfunction

  function automatic int count_er();
    int n = 0;
    foreach (cap_er[i]) n += int'(cap_er[i]);
    return n;
  endfunction

  task automatic fill_random(input int n);
    frame_q = {};
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
  endtask

  task automatic drive(input int d, input int nframes, input bit user, input int gap_at);
    int n;
    drv_ok = 1'b1;
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < frame_q.size(); i++) begin
        if (i == gap_at) begin
          tvalid[d] = 1'b0;
          repeat (4) @(posedge clk);
          #1;
        end
        tvalid[d] = 1'b1;
        tdata[d]  = frame_q[i];
        tlast[d]  = (i == frame_q.size() - 1);
        tuser[d]  = tlast[d] ? user : 1'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!tready[d] && n < 3000);
        if (!tready[d]) begin
          drv_ok = 1'b0;
          tvalid[d] = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
      end
    end
    tvalid[d] = 1'b0;
    tlast[d]  = 1'b0;
    tuser[d]  = 1'b0;
  endtask

  task automatic capture(input int d);
    int n = 0;
    cap_nib = {};
    cap_er  = {};
    cap_sp  = 0;
    cap_uf  = 0;
    cap_ok  = 1'b0;
    while (!tx_en[d]) begin
      if (n >= 5000) return;
      @(negedge clk);
      n++;
    end
    cap_ok = 1'b1;
    while (tx_en[d] && cap_nib.size() < 4000) begin
      cap_nib.push_back(txd[d]);
      cap_er.push_back(tx_er[d]);
      cap_sp += int'(sp[d]);
      cap_uf += int'(uf[d]);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({tready[d], txd[d], tx_en[d], tx_er[d], sp[d], uf[d]} !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b required 0", d,
                 {tready[d], txd[d], tx_en[d], tx_er[d], sp[d], uf[d]});
      end
    end
  endtask

  task automatic test_crc();
    logic [31:0] fcs_obs;
    int df;
    frame_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    build_expected(1'b0);
    fork drive(0, 1, 1'b0, -1); capture(0); join
    checks++;
    if (!(drv_ok && cap_ok)) begin errors++; $display("FAIL crc_handshake: drv=%0d cap=%0d required 1 1", drv_ok, cap_ok); end
    checks++;
    if (cap_nib.size() != 42) begin errors++; $display("FAIL crc_tx_en_len: got %0d required 42", cap_nib.size()); end
    df = first_diff(exp_nib.size());
    checks++;
    if (df != -1) begin errors++; $display("FAIL crc_frame: first differing nibble %0d required none", df); end
    fcs_obs = 32'd0;
    for (int i = 0; i < 8; i++) if (34 + i < cap_nib.size()) fcs_obs[4*i +: 4] = cap_nib[34+i];
    checks++;
    if (fcs_obs !== 32'hCBF43926) begin errors++; $display("FAIL crc_fcs_bytes: got %h required cbf43926", fcs_obs); end
    checks++;
    if (cap_sp != 1 || count_er() != 0) begin errors++; $display("FAIL crc_sp_er: sp=%0d er=%0d required 1 0", cap_sp, count_er()); end
    fill_random(20);
    build_expected(1'b0);
    fork drive(0, 1, 1'b0, -1); capture(0); join
    df = first_diff(exp_nib.size());
    checks++;
    if (cap_nib.size() != 64 || df != -1) begin
      errors++; $display("FAIL nopad_short: len=%0d diff=%0d required 64 -1", cap_nib.size(), df);
    end
  endtask

  task automatic test_padding();
    int df;
    frame_q = {};
    repeat (14) frame_q.push_back(8'h00);
    build_expected(1'b1);
    fork drive(1, 1, 1'b0, -1); capture(1); join
    checks++;
    if (cap_nib.size() != 144) begin errors++; $display("FAIL pad_tx_en_len: got %0d required 144", cap_nib.size()); end
    df = first_diff(exp_nib.size());
    checks++;
    if (df != -1) begin errors++; $display("FAIL pad_frame: first differing nibble %0d required none", df); end
  endtask

  task automatic test_random();
    int df, len;
    for (int f = 0; f < 5; f++) begin
      len = $urandom_range(1, 80);
      fill_random(len);
      build_expected(1'b1);
      fork drive(1, 1, 1'b0, -1); capture(1); join
      df = first_diff(exp_nib.size());
      checks++;
      if (cap_nib.size() != exp_nib.size() || df != -1 || cap_sp != 1) begin
        errors++;
        $display("FAIL random_frame len=%0d: got size %0d diff %0d sp %0d required %0d -1 1",
                 len, cap_nib.size(), df, cap_sp, exp_nib.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    int gap, d1, s1, sp1, d2;
    fill_random(64);
    build_expected(1'b1);
    fork
      drive(1, 2, 1'b0, -1);
      begin
        capture(1);
        d1 = first_diff(exp_nib.size());
        s1 = cap_nib.size();
        sp1 = cap_sp;
        gap = 0;
        while (!tx_en[1] && gap < 500) begin gap++; @(negedge clk); end
        capture(1);
      end
    join
    d2 = first_diff(exp_nib.size());
    checks++;
    if (s1 != exp_nib.size() || d1 != -1 || sp1 != 1) begin
      errors++; $display("FAIL b2b_first: size %0d diff %0d sp %0d required %0d -1 1", s1, d1, sp1, exp_nib.size());
    end
    checks++;
    if (gap != 24) begin errors++; $display("FAIL b2b_gap: got %0d required 24", gap); end
    checks++;
    if (cap_nib.size() != exp_nib.size() || d2 != -1 || cap_sp != 1) begin
      errors++; $display("FAIL b2b_second: size %0d diff %0d sp %0d required %0d -1 1",
                         cap_nib.size(), d2, cap_sp, exp_nib.size());
    end
  endtask

  task automatic test_underflow();
    int df;
    fill_random(40);
    build_expected(1'b1);
    fork drive(1, 1, 1'b0, 20); capture(1); join
    checks++;
    if (cap_uf != 1) begin errors++; $display("FAIL uf_pulse: got %0d required 1", cap_uf); end
    checks++;
    if (cap_nib.size() != 57) begin errors++; $display("FAIL uf_tx_en_len: got %0d required 57", cap_nib.size()); end
    checks++;
    if (count_er() != 1 || cap_er.size() == 0 || cap_er[cap_er.size()-1] !== 1'b1) begin
      errors++; $display("FAIL uf_tx_er: got %0d errored nibbles required 1 on the final nibble", count_er());
    end
    df = first_diff(56);
    checks++;
    if (df != -1) begin errors++; $display("FAIL uf_prefix: first differing nibble %0d required none", df); end
    checks++;
    if (!drv_ok) begin errors++; $display("FAIL uf_drain: got %0d required 1", drv_ok); end
  endtask

  task automatic test_bad_frame();
    int bad, df;
    fill_random(64);
    build_expected(1'b1);
    fork drive(1, 1, 1'b1, -1); capture(1); join
    bad = 0;
    foreach (cap_er[i]) if (cap_er[i] !== (i >= 144 && i < 152)) bad++;
    checks++;
    if (cap_nib.size() != 152 || bad != 0) begin
      errors++; $display("FAIL bad_frame_er: size %0d wrong er nibbles %0d required 152 0", cap_nib.size(), bad);
    end
    df = first_diff(exp_nib.size());
    checks++;
    if (df != -1) begin errors++; $display("FAIL bad_frame_data: first differing nibble %0d required none", df); end
  endtask

  task automatic test_reset_midframe();
    int n, df;
    tvalid[1] = 1'b1;
    tlast[1]  = 1'b0;
    tuser[1]  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tdata[1] = 8'($urandom);
      n = 0;
      do begin @(negedge clk); n++; end while (!tready[1] && n < 3000);
      @(posedge clk);
      #1;
    end
    checks++;
    if (tx_en[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_tx_en: got %b required 1", tx_en[1]); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({tready[1], txd[1], tx_en[1], tx_er[1], sp[1], uf[1]} !== 9'd0) begin
      errors++; $display("FAIL async_reset_outputs: got %b required 0",
                         {tready[1], txd[1], tx_en[1], tx_er[1], sp[1], uf[1]});
    end
    tvalid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random(30);
    build_expected(1'b1);
    fork drive(1, 1, 1'b0, -1); capture(1); join
    df = first_diff(exp_nib.size());
    checks++;
    if (cap_nib.size() != exp_nib.size() || df != -1 || cap_sp != 1) begin
      errors++; $display("FAIL post_reset_frame: size %0d diff %0d sp %0d required %0d -1 1",
                         cap_nib.size(), df, cap_sp, exp_nib.size());
    end
  endtask

  initial begin
    build_table();
    for (int d = 0; d < 2; d++) begin
      tdata[d] = 8'h00; tvalid[d] = 1'b0; tlast[d] = 1'b0; tuser[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_crc();
    test_padding();
    test_random();
    test_back_to_back();
    test_underflow();
    test_bad_frame();
    test_reset_midframe();
    checks++;
    if (tr_viol != 0) begin errors++; $display("FAIL tready_spacing: got %0d back-to-back cycles required 0", tr_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
